// File: rtl/probe_serializer.sv
// probe_serializer
//   Snapshots a parallel probe word and shifts it out as a UART-like frame:
//   one start bit (0), WIDTH payload bits LSB first, an optional even-parity
//   bit, then one stop bit (1). Every bit lasts DIV clk cycles.
//
// Parameters
//   WIDTH   payload bits per frame (1..32)
//   DIV     clk cycles per serial bit (1..256)
//   PARITY  0: no parity bit, 1: even-parity bit after the payload
//
// Ports
//   clk      sole clock, rising edge
//   rst_n    asynchronous active-low reset
//   capture  snapshot request
//   data_in  parallel word to serialize
//   sout     serial line, idles high
//   busy     high while a frame is in progress
//   done     one-cycle pulse in the cycle after the last stop-bit cycle
//   overrun  one-cycle pulse the cycle after a capture that arrived while busy
//
// Handshake: capture acts as valid and (busy == 0) acts as ready. A capture
// sampled at a rising edge while not busy is accepted and data_in is copied
// into the shadow register on that edge; a capture sampled while busy is
// dropped and reported through overrun on the next cycle. The done cycle is
// already idle, so a capture held there starts the next frame immediately.
module probe_serializer #(
    parameter int WIDTH  = 8,
    parameter int DIV    = 4,
    parameter int PARITY = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,
    input  logic [WIDTH-1:0] data_in,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    // Counter widths never drop to zero, even for DIV=1 or WIDTH=1.
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    bit_cnt;
    logic [IW-1:0]    bit_idx;
    logic [WIDTH-1:0] shadow;
    logic             bit_end;

    assign bit_end = (bit_cnt == CNT_MAX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (capture) state_nxt = S_START;
            end
            S_START: begin
                if (bit_end) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (bit_end && (bit_idx == IDX_MAX)) begin
                    state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
                end
            end
            S_PAR: begin
                if (bit_end) state_nxt = S_STOP;
            end
            S_STOP: begin
                if (bit_end) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: decoded straight from state so that an asynchronous
    // reset forces sout high and busy low without waiting for an edge.
    always_comb begin
        sout = 1'b1;
        busy = 1'b1;
        case (state)
            S_IDLE:  busy = 1'b0;
            S_START: sout = 1'b0;
            S_DATA:  sout = shadow[bit_idx];
            S_PAR:   sout = ^shadow;
            S_STOP:  sout = 1'b1;
            default: begin
                sout = 1'b1;
                busy = 1'b0;
            end
        endcase
    end

    // Bit timer: runs 0..DIV-1 in every non-idle state and wraps at each
    // bit boundary; parked at 0 while idle so a new frame starts aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (state == S_IDLE || bit_end) begin
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt + CW'(1);
        end
    end

    // Payload bit index, only advances inside DATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= '0;
        end else if (state != S_DATA) begin
            bit_idx <= '0;
        end else if (bit_end) begin
            bit_idx <= (bit_idx == IDX_MAX) ? '0 : bit_idx + IW'(1);
        end
    end

    // Shadow register: loaded only on an accepted capture, so later
    // data_in changes cannot disturb the frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (state == S_IDLE && capture) begin
            shadow <= data_in;
        end
    end

    // Status pulses, each one cycle wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            done    <= (state == S_STOP) && bit_end;
            overrun <= (state != S_IDLE) && capture;
        end
    end

endmodule

// File: doc/probe_serializer.md
PROBE_SERIALIZER -- requirements
Module: probe_serializer

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8: number of payload bits per frame (legal range 1..32).
REQ-002 The block SHALL take parameter DIV, default 4: clk cycles per serial bit (legal range 1..256).
REQ-003 The block SHALL take parameter PARITY, default 0: 0 means no parity bit; 1 means an even-parity bit is inserted after the payload.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 capture  input  1  request to snapshot data_in and transmit it.
REQ-007 data_in  input  WIDTH  parallel word to serialize, e.g. probed cell outputs.
REQ-008 sout  output  1  serial line; idles high.
REQ-009 busy  output  1  high while a frame is in progress.
REQ-010 done  output  1  one-cycle pulse at frame completion.
REQ-011 overrun  output  1  one-cycle pulse when capture arrives while busy.

Function
REQ-012 The FSM SHALL have the states IDLE, START, DATA, PAR and STOP.
REQ-013 In IDLE with capture=1 at an edge, the block SHALL latch data_in into a shadow register and enter START; data_in changes after that edge SHALL NOT affect the frame.
REQ-014 busy SHALL be 1 in every state except IDLE, becoming 1 the cycle after the accepting edge.
REQ-015 Each of START, each DATA bit, PAR and STOP SHALL last exactly DIV cycles, timed by a bit counter that runs 0..DIV-1 and wraps.
REQ-016 sout SHALL be 0 in START; in DATA it SHALL carry shadow bit 0 first, then bit 1, up to bit WIDTH-1 (LSB first); it SHALL be 1 in STOP and IDLE.
REQ-017 PAR SHALL be entered only when PARITY=1; sout in PAR SHALL equal the XOR of all shadow bits, so the count of ones across payload plus parity is even.
REQ-018 The total frame length SHALL be DIV*(WIDTH+2+PARITY) cycles, from the first busy=1 cycle through the last STOP cycle.
REQ-019 After the last STOP cycle the block SHALL return to IDLE, with done=1 for exactly that one cycle and busy=0.
REQ-020 capture=1 in the same cycle done=1 SHALL be accepted, giving back-to-back frames with no idle gap.
REQ-021 capture=1 while busy=1 SHALL be ignored and SHALL produce overrun=1 on the following cycle; the current frame SHALL continue unaffected.
REQ-022 The payload bit index SHALL be a counter of ceil(log2(WIDTH)) bits or more, and the transition to PAR or STOP SHALL occur when the index reaches WIDTH-1 and the bit counter reaches DIV-1.
REQ-023 With DIV=1, each bit SHALL last one cycle and there SHALL be no extra cycles.

Reset
REQ-024 While rst_n=0, the block SHALL be in IDLE with sout=1, busy=0, done=0, overrun=0, the shadow register at 0 and all counters at 0, regardless of clk.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately (sout=1 asynchronously); no done pulse SHALL follow.
REQ-026 After rst_n deasserts, capture SHALL be accepted on the first rising clk edge.

Verification
REQ-027 Scenario (WIDTH=8, DIV=4, PARITY=0): capture with data_in=0xA5 -> sout sequence 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles; busy high for 40 cycles; done pulses once.
REQ-028 Scenario (same parameters with PARITY=1): capture with 0xA5 -> parity bit 0, frame of 44 cycles; capture with 0x01 -> parity bit 1.
REQ-029 Scenario: change data_in to 0xFF one cycle after capture of 0x3C -> the transmitted payload is still 0x3C.
REQ-030 Scenario: capture pulse at cycle 10 of a frame -> overrun=1 at cycle 11, frame unchanged, no second frame; capture held high on the done cycle -> second frame starts immediately with start bit 0.
REQ-031 Scenario: rst_n low at cycle 20 of a frame -> sout=1, busy=0 without a clk edge; no done pulse; a fresh capture after release transmits correctly.
REQ-032 Scenario (DIV=1, WIDTH=1): capture with data_in=1 -> sout 0,1,1 on consecutive cycles, then done.
